rand_mem_read_arbiter: RTL

Round-robin arbiter that shares a single memory read port between NUM_REQ random-read pipeline stages. It sits between the requesters' mem_read/mem_addr/mem_resp/mem_rdata interface and the memory. It allows one outstanding memory read at a time, with registered outputs on both sides. Grant fairness uses a rotating priority pointer.

---
 rtl/rand_mem_read_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/rand_mem_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rand_mem_read_arbiter
//  Purpose  : Round-robin arbiter sharing one memory read port among NUM_REQ
//             requesters, one outstanding read at a time, registered outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module rand_mem_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_read,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_resp,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic                          mem_read,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic                          mem_resp,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic                          busy,
    output logic [IDX_W-1:0]              grant_idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [IDX_W-1:0]        r_grant_idx;
    logic                    r_mem_read;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [NUM_REQ-1:0]      r_req_resp;
    logic [DATA_WIDTH-1:0]   r_req_rdata;
    logic                    r_busy;

    logic                    w_any;
    logic [IDX_W-1:0]        w_win;
    int                      w_sum;

    // First set request bit at or above the priority pointer, wrapping to 0.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_sum = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = int'(r_rr_ptr) + k;
            if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
            if (!w_any && req_read[w_sum]) begin
                w_any = 1'b1;
                w_win = w_sum[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_mem_read  <= 1'b0;
            r_mem_addr  <= '0;
            r_req_resp  <= '0;
            r_req_rdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant_idx <= w_win;
                        r_mem_addr  <= req_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
                        r_mem_read  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mem_resp) begin
                        r_mem_read  <= 1'b0;
                        r_req_rdata <= mem_rdata;
                        r_req_resp  <= NUM_REQ'(1) << r_grant_idx;
                        r_rr_ptr    <= (r_grant_idx == IDX_W'(NUM_REQ-1)) ? '0
                                                                           : r_grant_idx + 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Skipping arbitration here lets the served requester drop its request.
                    r_req_resp <= '0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_mem_read <= 1'b0;
                    r_req_resp <= '0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign req_resp  = r_req_resp;
    assign req_rdata = r_req_rdata;
    assign mem_read  = r_mem_read;
    assign mem_addr  = r_mem_addr;
    assign busy      = r_busy;
    assign grant_idx = r_grant_idx;

endmodule
`default_nettype wire
